// File: rtl/elevator_pkg.sv
// Shared floor-encoding definitions for the elevator datapath.
// The one-hot decoder and the request encoder both import this package,
// so the two ends agree on what a floor code means.
//   NUM_FLOORS  : number of served floors; bit i of a vector = floor i+1
//   FLOOR_W     : width of a binary floor code
//   FLOOR_NONE  : reserved "no floor / unknown" code
//   floor_valid : 1 when a code names a real floor (1..NUM_FLOORS)
package elevator_pkg;

    localparam int NUM_FLOORS = 5;
    localparam int FLOOR_W    = 4;
    localparam logic [FLOOR_W-1:0] FLOOR_NONE = 4'b1111;

    function automatic logic floor_valid(input logic [FLOOR_W-1:0] code);
        return (code >= FLOOR_W'(1)) && (code <= FLOOR_W'(NUM_FLOORS))
               && (code != FLOOR_NONE);
    endfunction

endpackage

// File: rtl/floor_onehot_encoder.sv
// Combinational binary floor code -> one-hot vector.
//   code   in  FLOOR_W     binary floor number
//   onehot out NUM_FLOORS  bit k-1 set for code k in 1..NUM_FLOORS, else 0
//   valid  out 1           code names a real floor
module floor_onehot_encoder
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = NUM_FLOORS,
    parameter int CODE_W   = FLOOR_W
) (
    input  logic [CODE_W-1:0]   code,
    output logic [N_FLOORS-1:0] onehot,
    output logic                valid
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            onehot[i] = (code == CODE_W'(i + 1));
        end
    end

    // Any out-of-range code (including the all-ones "none") leaves onehot zero.
    assign valid = |onehot;

endmodule

// File: rtl/floor_request_encoder.sv
// Latches hall/car floor requests until served and reports car position.
//   clk, rst       clock, synchronous active-high reset
//   req_valid/req_floor       request strobe + binary floor
//   served_valid/served_floor car stopped at floor, clear its request
//   cur_floor      binary car position (all-ones = unknown)
//   pending        outstanding requests, bit i = floor i+1
//   floor_lamp     registered one-hot position, zero when unknown
//   any_pending    OR of pending
//   pending_above  a pending floor lies strictly above the lamp floor
//   pending_below  a pending floor lies strictly below the lamp floor
//   req_err        one-cycle pulse after a request with an invalid code
// Each pending bit is its own IDLE/PENDING state; there is no global FSM.
module floor_request_encoder
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic                  served_valid,
    input  logic [FLOOR_W-1:0]    served_floor,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [NUM_FLOORS-1:0] floor_lamp,
    output logic                  any_pending,
    output logic                  pending_above,
    output logic                  pending_below,
    output logic                  req_err
);

    logic [NUM_FLOORS-1:0] req_oh, srv_oh, cur_oh;
    logic                  req_ok, srv_ok, cur_ok;
    logic                  req_none;
    logic [NUM_FLOORS-1:0] set_vec, clr_vec;
    logic [NUM_FLOORS-1:0] above_mask, below_mask;

    floor_onehot_encoder #(.N_FLOORS(NUM_FLOORS), .CODE_W(FLOOR_W)) u_req_enc (
        .code(req_floor), .onehot(req_oh), .valid(req_ok)
    );
    floor_onehot_encoder #(.N_FLOORS(NUM_FLOORS), .CODE_W(FLOOR_W)) u_srv_enc (
        .code(served_floor), .onehot(srv_oh), .valid(srv_ok)
    );
    floor_onehot_encoder #(.N_FLOORS(NUM_FLOORS), .CODE_W(FLOOR_W)) u_cur_enc (
        .code(cur_floor), .onehot(cur_oh), .valid(cur_ok)
    );

    assign req_none = (req_floor == {FLOOR_W{1'b1}});
    assign set_vec  = (req_valid && req_ok)    ? req_oh : '0;
    assign clr_vec  = (served_valid && srv_ok) ? srv_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            floor_lamp <= '0;
            req_err    <= 1'b0;
        end else begin
            // Clear applied after set: a same-floor request and serve drops
            // the request since the car is already at that floor.
            pending    <= (pending | set_vec) & ~clr_vec;
            floor_lamp <= cur_ok ? cur_oh : '0;
            req_err    <= req_valid && !req_ok && !req_none;
        end
    end

    // Masks built from the registered one-hot lamp: a running OR from the
    // bottom marks every bit above the lamp bit, from the top every bit below.
    // An all-zero lamp (unknown position) yields empty masks.
    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 1; i < NUM_FLOORS; i++) begin
            above_mask[i] = above_mask[i-1] | floor_lamp[i-1];
        end
        for (int i = NUM_FLOORS - 2; i >= 0; i--) begin
            below_mask[i] = below_mask[i+1] | floor_lamp[i+1];
        end
    end

    assign any_pending   = |pending;
    assign pending_above = |(pending & above_mask);
    assign pending_below = |(pending & below_mask);

endmodule

// File: doc/floor_request_encoder.md
# floor_request_encoder

Inverse direction of the elevator's one-hot floor decoder. It encodes binary floor numbers (1..5, 4'b1111 = "no floor") into a registered 5-bit one-hot request vector, and holds pending hall/car requests until the car reports them served. It also produces a one-hot position lamp and above/below summary flags. Its `pending` output feeds the priority decoder that selects the next target floor.

## Interface
- `NUM_FLOORS`, default 5: number of floors; bit i of every vector represents floor i+1.
- `FLOOR_W`, default 4: width of binary floor codes.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request strobe, one cycle per request.
- `req_floor`  in  FLOOR_W  requested floor number.
- `served_valid`  in  1  car has stopped at `served_floor` and opened its door.
- `served_floor`  in  FLOOR_W  floor being served.
- `cur_floor`  in  FLOOR_W  current car position (binary; 4'b1111 = between floors/unknown).
- `pending`  out  NUM_FLOORS  latched outstanding requests, one bit per floor.
- `floor_lamp`  out  NUM_FLOORS  one-hot current position; all zero when unknown.
- `any_pending`  out  1  OR of `pending`.
- `pending_above`  out  1  some pending floor is strictly above the registered current floor.
- `pending_below`  out  1  some pending floor is strictly below the registered current floor.
- `req_err`  out  1  one-cycle pulse: `req_valid` carried an invalid code.

## Operation
- Encoding: code k with 1 ≤ k ≤ NUM_FLOORS maps to bit k-1. 4'b1111 is "no floor" and encodes to all zeros silently. Every other code (0, 6..14) also encodes to all zeros and is invalid.
- Request: when `req_valid` is high with a valid code, the corresponding `pending` bit is set. Setting an already-set bit is a no-op.
- Invalid request: when `req_valid` is high with an invalid code, `pending` is unchanged and `req_err` is 1 on the next cycle. 4'b1111 with `req_valid` neither sets a bit nor raises `req_err`.
- Serve: when `served_valid` is high with a valid code, the corresponding bit is cleared. An invalid `served_floor` is ignored and raises no error.
- Same-cycle set and clear:
  - Same floor: clear wins, because the car is already there and the request is dropped.
  - Different floors: both take effect.
- Request for the current floor:
  - If `served_valid` is low that cycle, the request is latched normally.
  - Door reopening is the controller's job, not this block's.
- Position: `cur_floor` is registered each cycle into `floor_lamp` as one-hot. An unknown or invalid code gives all zeros.
- Above/below flags are computed from registered `pending` and the registered position.
  - With unknown position, both flags are 0, even if `any_pending` is 1.
- State bookkeeping: there are 2 states per floor bit (IDLE/PENDING). The register vector is the state machine, with no global FSM.

## Timing
- Reset: all outputs and registers go to 0 on the first rising edge with `rst` high. This includes `pending`, `floor_lamp`, `any_pending`, `pending_above`, `pending_below` and `req_err`. Reset overrides any same-cycle request or serve.
- Reset mid-operation: all pending requests are lost. No replay.
- Latency:
  - A request or serve sampled at edge N is visible on `pending` after edge N.
  - `any_pending`, `pending_above` and `pending_below` track `pending` in the same cycle (derived combinationally from registers only).
  - `floor_lamp` lags `cur_floor` by 1 cycle.
  - `req_err` is asserted for exactly 1 cycle after the offending edge.
- No handshake back-pressure: every `req_valid` cycle is consumed. Back-to-back requests on consecutive cycles are all latched.
- All outputs are glitch-free register or register-derived values. There are no combinational input-to-output paths.

## Structure
- Package `elevator_pkg`:
  - `NUM_FLOORS`, `FLOOR_W`, `FLOOR_NONE` = 4'b1111.
  - Function `floor_valid(code)`.
  - Shared with the one-hot decoder so both ends agree on the encoding.
- Sub-module `floor_onehot_encoder`: combinational binary→one-hot plus `valid` flag. It is instantiated three times, for `req_floor`, `served_floor` and `cur_floor`.
- The top level holds the pending register, lamp register, error flop and above/below masking logic.
  - Above mask: bits whose index is greater than the current floor index.
  - Below mask: bits whose index is less than the current floor index.

## Test plan
- Reset, then `req_valid` with floor 3, then floor 5 on consecutive cycles → `pending`=5'b00100, then 5'b10100. `any_pending`=1. `req_err` stays 0.
- With `cur_floor`=2 and `pending`=5'b10100 → `floor_lamp`=5'b00010, `pending_above`=1, `pending_below`=0. Then `cur_floor`=4'b1111 → lamp 0, both flags 0, `any_pending`=1.
- Same cycle: request floor 4 and serve floor 4, with `pending`=0 → `pending` stays 0. Same cycle: request floor 1 and serve floor 5, with `pending`=5'b10000 → `pending`=5'b00001.
- `req_valid` with 0, then 7, then 4'b1111 → `req_err` pulses 1,1,0 on the following cycles. `pending` is unchanged throughout.
- `pending`=5'b11111, `cur_floor`=3; assert `rst` for 1 cycle together with a floor-2 request → all outputs 0 after the edge. Next cycle, a floor-2 request → `pending`=5'b00010.
- Serve floors 1..5 sequentially from `pending`=5'b11111 → bits clear one per cycle. `any_pending` falls on the cycle `pending` reaches 0.
